// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer SPI link: register map, command-byte fields and
// the transaction FSM state encoding used by both the master and the responder.
package accel_pkg;

   localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
   localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
   localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
   localparam logic [5:0] ADDR_STATUS    = 6'h27;
   localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
   localparam logic [5:0] ADDR_OUT_X_H   = 6'h29;
   localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
   localparam logic [5:0] ADDR_OUT_Y_H   = 6'h2B;
   localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;
   localparam logic [5:0] ADDR_OUT_Z_H   = 6'h2D;

   localparam int CMD_RW_BIT   = 7;
   localparam int CMD_MS_BIT   = 6;
   localparam int STATUS_ZYXDA = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } spi_state_e;

   typedef struct packed {
      spi_state_e state;
      logic [2:0] bit_cnt;
      logic [5:0] addr;
      logic       spc_sync;
   } resp_dbg_t;

   function automatic logic is_writable(input logic [5:0] addr);
      return (addr == ADDR_CTRL_REG1) || (addr == ADDR_CTRL_REG4);
   endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, with single-cycle rise/fall pulses
// derived from the synchronized level.
module spi_pin_sync #(
   parameter logic RST_VAL = 1'b1
)(
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic       meta_q;
   logic       sync_q;
   logic       prev_q;
   logic [1:0] settle_q;
   logic       armed;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q   <= RST_VAL;
         sync_q   <= RST_VAL;
         prev_q   <= RST_VAL;
         settle_q <= 2'd0;
      end else begin
         meta_q <= pin_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
      end
   end

   // A reset while the pin sits away from RST_VAL must not fake an edge once the chain refills.
   assign armed  = (settle_q == 2'd3);
   assign sync_o = sync_q;
   assign rise_o = armed &  sync_q & ~prev_q;
   assign fall_o = armed & ~sync_q &  prev_q;

endmodule

// File: rtl/accel_spi_responder.sv
// Mode-3 SPI target presenting a 3-axis accelerometer register map; all pins are
// oversampled in the clk domain and edges act three clk cycles after the pin changes.
module accel_spi_responder
   import accel_pkg::*;
#(
   parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
   parameter logic [7:0] CTRL1_RST    = 8'h07
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        SPC,
   input  logic        SDI,
   input  logic        CS,
   output logic        SDO,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   input  logic [15:0] sample_z,
   input  logic        sample_valid,
   output logic [7:0]  ctrl_reg1,
   output logic [7:0]  ctrl_reg4,
   output logic        wr_pulse,
   output logic        busy,
   output resp_dbg_t   dbg_o
);

   logic spc_sync, spc_rise, spc_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic sdi_meta_q, sdi_q;

   spi_pin_sync #(.RST_VAL(1'b1)) u_spc_sync (
      .clk(clk), .rst(rst), .pin_i(SPC),
      .sync_o(spc_sync), .rise_o(spc_rise), .fall_o(spc_fall)
   );

   spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .rst(rst), .pin_i(CS),
      .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
   );

   spi_state_e  state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [5:0]  addr_q, addr_d;
   logic        rw_q, rw_d;
   logic        ms_q, ms_d;
   logic [6:0]  shift_in_q, shift_in_d;
   logic [7:0]  shift_out_q, shift_out_d;
   logic [7:0]  ctrl1_q, ctrl1_d;
   logic [7:0]  ctrl4_q, ctrl4_d;
   logic        wr_pulse_q, wr_pulse_d;
   logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_z_q, pend_z_d;
   logic        pend_valid_q, pend_valid_d;
   logic        zyxda_q, zyxda_d;

   logic [7:0]  byte_in;
   logic [7:0]  rd_data;
   logic        byte_done;
   logic        in_xfer;
   logic        zyxda_set, zyxda_clr;

   assign byte_in   = {shift_in_q, sdi_q};
   assign in_xfer   = (state_q != IDLE) && !cs_rise;
   assign byte_done = in_xfer && spc_rise && (bit_cnt_q == 3'd7);

   always_comb begin
      rd_data = 8'h00;
      case (addr_q)
         ADDR_WHO_AM_I:  rd_data = WHO_AM_I_VAL;
         ADDR_CTRL_REG1: rd_data = ctrl1_q;
         ADDR_CTRL_REG4: rd_data = ctrl4_q;
         ADDR_STATUS:    rd_data = 8'(zyxda_q) << STATUS_ZYXDA;
         ADDR_OUT_X_L:   rd_data = x_q[7:0];
         ADDR_OUT_X_H:   rd_data = x_q[15:8];
         ADDR_OUT_Y_L:   rd_data = y_q[7:0];
         ADDR_OUT_Y_H:   rd_data = y_q[15:8];
         ADDR_OUT_Z_L:   rd_data = z_q[7:0];
         ADDR_OUT_Z_H:   rd_data = z_q[15:8];
         default:        rd_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (cs_rise) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (cs_fall) state_d = CMD;
            CMD:     if (spc_rise && bit_cnt_q == 3'd7) state_d = DATA;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      addr_d       = addr_q;
      rw_d         = rw_q;
      ms_d         = ms_q;
      shift_in_d   = shift_in_q;
      shift_out_d  = shift_out_q;
      ctrl1_d      = ctrl1_q;
      ctrl4_d      = ctrl4_q;
      wr_pulse_d   = 1'b0;
      x_d          = x_q;
      y_d          = y_q;
      z_d          = z_q;
      pend_x_d     = pend_x_q;
      pend_y_d     = pend_y_q;
      pend_z_d     = pend_z_q;
      pend_valid_d = pend_valid_q;
      zyxda_set    = 1'b0;
      zyxda_clr    = 1'b0;

      if (cs_rise || (state_q == IDLE && cs_fall)) begin
         bit_cnt_d   = 3'd0;
         shift_out_d = 8'h00;
      end else if (in_xfer && spc_rise) begin
         shift_in_d = byte_in[6:0];
         bit_cnt_d  = bit_cnt_q + 3'd1;
         if (byte_done && state_q == CMD) begin
            rw_d   = byte_in[CMD_RW_BIT];
            ms_d   = byte_in[CMD_MS_BIT];
            addr_d = byte_in[5:0];
         end else if (byte_done) begin
            if (!rw_q && is_writable(addr_q)) begin
               wr_pulse_d = 1'b1;
               if (addr_q == ADDR_CTRL_REG1) ctrl1_d = byte_in;
               else                          ctrl4_d = byte_in;
            end
            if (rw_q && addr_q == ADDR_OUT_Z_H) zyxda_clr = 1'b1;
            if (ms_q) addr_d = addr_q + 6'd1;
         end
      end else if (in_xfer && spc_fall && state_q == DATA && rw_q) begin
         // Counter at zero on a fall means a fresh byte: fetch it so a burst sees current data.
         shift_out_d = (bit_cnt_q == 3'd0) ? rd_data : {shift_out_q[6:0], 1'b0};
      end

      if (sample_valid && cs_sync) begin
         x_d          = sample_x;
         y_d          = sample_y;
         z_d          = sample_z;
         zyxda_set    = 1'b1;
         pend_valid_d = 1'b0;
      end else if (sample_valid) begin
         pend_x_d     = sample_x;
         pend_y_d     = sample_y;
         pend_z_d     = sample_z;
         pend_valid_d = 1'b1;
      end else if (cs_rise && pend_valid_q) begin
         x_d          = pend_x_q;
         y_d          = pend_y_q;
         z_d          = pend_z_q;
         zyxda_set    = 1'b1;
         pend_valid_d = 1'b0;
      end

      zyxda_d = zyxda_set ? 1'b1 : (zyxda_clr ? 1'b0 : zyxda_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 3'd0;
         addr_q       <= 6'd0;
         rw_q         <= 1'b0;
         ms_q         <= 1'b0;
         shift_in_q   <= 7'd0;
         shift_out_q  <= 8'h00;
         ctrl1_q      <= CTRL1_RST;
         ctrl4_q      <= 8'h00;
         wr_pulse_q   <= 1'b0;
         x_q          <= 16'h0000;
         y_q          <= 16'h0000;
         z_q          <= 16'h0000;
         pend_x_q     <= 16'h0000;
         pend_y_q     <= 16'h0000;
         pend_z_q     <= 16'h0000;
         pend_valid_q <= 1'b0;
         zyxda_q      <= 1'b0;
         sdi_meta_q   <= 1'b0;
         sdi_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         addr_q       <= addr_d;
         rw_q         <= rw_d;
         ms_q         <= ms_d;
         shift_in_q   <= shift_in_d;
         shift_out_q  <= shift_out_d;
         ctrl1_q      <= ctrl1_d;
         ctrl4_q      <= ctrl4_d;
         wr_pulse_q   <= wr_pulse_d;
         x_q          <= x_d;
         y_q          <= y_d;
         z_q          <= z_d;
         pend_x_q     <= pend_x_d;
         pend_y_q     <= pend_y_d;
         pend_z_q     <= pend_z_d;
         pend_valid_q <= pend_valid_d;
         zyxda_q      <= zyxda_d;
         sdi_meta_q   <= SDI;
         sdi_q        <= sdi_meta_q;
      end
   end

   assign SDO       = shift_out_q[7];
   assign ctrl_reg1 = ctrl1_q;
   assign ctrl_reg4 = ctrl4_q;
   assign wr_pulse  = wr_pulse_q;
   assign busy      = ~cs_sync;
   assign dbg_o     = '{state: state_q, bit_cnt: bit_cnt_q, addr: addr_q, spc_sync: spc_sync};

endmodule
